pipeline_ctrl: RTL and testbench

- Central stall/flush controller for the five-stage pipeline; drives the `writeEN`/`flush` pair of every inter-stage latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable.
- Resolves data-memory wait, taken branches/jumps resolved in MEM, load-use hazards, instruction-fetch misses and halt drain.
- Its only state is a small FSM plus two performance counters. It is the initiator of the enable/flush protocol that the pipeline latches respond to.

---
 rtl/cpu_types_pkg.sv | 12 +
 rtl/hazard_detect.sv | 19 +
 rtl/pipeline_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and pipeline controller state.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: load in EX writes a register read by ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dren,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);

  logic hit;

  assign hit = (ex_rt == id_rs) || (ex_rt == id_rt);

  // r0 is hardwired, so a load into it never creates a hazard
  assign load_use = ex_dren && (ex_rt != '0) && hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  input  logic             ex_dren,
  input  regbits_t         ex_rt,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pctrl_state_t     state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic load_use;
  logic halted;
  logic dwait;
  logic ev_halt, ev_dwait, ev_redir, ev_lu, ev_imiss;

  hazard_detect u_hazard (
    .ex_dren  (ex_dren),
    .ex_rt    (ex_rt),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (load_use)
  );

  assign halted = (state_q == HALTED);
  assign dwait  = (mem_dren | mem_dwen) & ~dhit;

  // One-hot event select, highest priority first
  assign ev_halt  = ~halted & mem_halt;
  assign ev_dwait = ~halted & ~mem_halt & dwait;
  assign ev_redir = ~halted & ~mem_halt & ~dwait
                  & mem_redirect;
  assign ev_lu    = ~halted & ~mem_halt & ~dwait
                  & ~mem_redirect & load_use;
  assign ev_imiss = ~halted & ~mem_halt & ~dwait
                  & ~mem_redirect & ~load_use & ~ihit;

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;
    if (!halted) state_d = RUN;
    unique case (1'b1)
      halted: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      ev_halt: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = HALTED;
      end
      ev_dwait: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_flush = 1'b1;
        state_d     = MEMWAIT;
      end
      ev_redir: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      ev_lu: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      ev_imiss: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!halted && !pc_en) stall_d = stall_q + CNT_W'(1);
    if (ev_redir)          flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halt      = halted;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table plus corner sequences.
module tb_pipeline_ctrl;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_dren, mem_dwen;
  logic        mem_redirect, mem_halt, ex_dren;
  regbits_t    ex_rt, id_rs, id_rt;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
  logic        halt;
  logic [31:0] stall_cnt, flush_cnt;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen),
    .mem_redirect(mem_redirect), .mem_halt(mem_halt),
    .ex_dren(ex_dren), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt),
    .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic ihit, dhit, dren, dwen, redir, mhalt, exdren;
    logic [4:0] exrt, rs, rt;
  } vin_t;

  typedef struct {
    vin_t       in;
    logic [8:0] out;
  } vec_t;

  typedef struct {
    logic [8:0]  out;
    logic        halt;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  // {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
  localparam logic [8:0] O_DEF  = 9'b1_10_10_10_10;
  localparam logic [8:0] O_IMIS = 9'b0_11_10_10_10;
  localparam logic [8:0] O_LU   = 9'b0_00_11_10_10;
  localparam logic [8:0] O_RDR  = 9'b1_11_11_11_10;
  localparam logic [8:0] O_DW   = 9'b0_00_00_00_11;
  localparam logic [8:0] O_HLT  = 9'b0_11_11_11_10;
  localparam logic [8:0] O_OFF  = 9'b0_00_00_00_00;

  exp_t        sbq[$];
  vec_t        vt[11];
  int          checks = 0;
  int          errors = 0;
  logic        m_halted;
  logic [31:0] m_stall, m_flush;

  function automatic vin_t mk(
    logic ih, logic dh, logic dr, logic dw, logic rd,
    logic mh, logic ed, logic [4:0] er, logic [4:0] rs,
    logic [4:0] rt);
    vin_t v;
    v = '{ih, dh, dr, dw, rd, mh, ed, er, rs, rt};
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask

  task automatic apply(vin_t v);
    ihit = v.ihit; dhit = v.dhit;
    mem_dren = v.dren; mem_dwen = v.dwen;
    mem_redirect = v.redir; mem_halt = v.mhalt;
    ex_dren = v.exdren; ex_rt = v.exrt;
    id_rs = v.rs; id_rt = v.rt;
  endtask

  task automatic step(string n, vin_t v, logic [8:0] eo);
    exp_t e, g;
    logic busy;
    @(posedge CLK);
    #1;
    apply(v);
    e.out = eo; e.halt = m_halted;
    e.stall = m_stall; e.flush = m_flush;
    sbq.push_back(e);
    busy = (v.dren | v.dwen) & ~v.dhit;
    if (!m_halted) begin
      if (!eo[8]) m_stall++;
      if (v.redir && !v.mhalt && !busy) m_flush++;
      if (v.mhalt) m_halted = 1'b1;
    end
    @(negedge CLK);
    if (sbq.size() == 0) begin
      chk({n, "_sbq"}, 32'd0, 32'd1);
    end else begin
      g = sbq.pop_front();
      chk({n, "_out"}, {23'd0, pc_en, ifid_en, ifid_flush,
        idex_en, idex_flush, exmem_en, exmem_flush,
        memwb_en, memwb_flush}, {23'd0, g.out});
      chk({n, "_halt"}, {31'd0, halt}, {31'd0, g.halt});
      chk({n, "_stall"}, stall_cnt, g.stall);
      chk({n, "_flush"}, flush_cnt, g.flush);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    apply(mk(1,0,0,0,0,0,0,0,0,0));
    @(negedge CLK);
    nRST = 1'b1;
    m_halted = 1'b0; m_stall = '0; m_flush = '0;
    sbq.delete();
  endtask

  vin_t idle, dw, dok;

  initial begin
    nRST = 1'b0;
    apply(mk(1,0,0,0,0,0,0,0,0,0));
    idle = mk(1,0,0,0,0,0,0,0,0,0);
    dw   = mk(1,0,1,0,0,0,0,0,0,0);
    dok  = mk(1,1,1,0,0,0,0,0,0,0);

    vt[0]  = '{mk(1,0,0,0,0,0,0,0,0,0), O_DEF};
    vt[1]  = '{mk(0,0,0,0,0,0,0,0,0,0), O_IMIS};
    vt[2]  = '{mk(1,0,0,0,0,0,1,8,8,3), O_LU};
    vt[3]  = '{mk(1,0,0,0,0,0,1,9,4,9), O_LU};
    vt[4]  = '{mk(1,0,0,0,0,0,1,0,0,0), O_DEF};
    vt[5]  = '{mk(1,0,0,0,0,0,0,8,8,8), O_DEF};
    vt[6]  = '{mk(0,0,0,0,0,0,1,8,8,3), O_LU};
    vt[7]  = '{mk(0,0,0,0,1,0,0,0,0,0), O_RDR};
    vt[8]  = '{mk(1,0,0,0,1,0,1,8,8,8), O_RDR};
    vt[9]  = '{mk(1,1,1,0,1,0,0,0,0,0), O_RDR};
    vt[10] = '{mk(1,1,0,1,0,0,0,0,0,0), O_DEF};

    do_reset();
    for (int i = 0; i < 11; i++)
      step($sformatf("vec%0d", i), vt[i].in, vt[i].out);

    // Data-memory wait: three stalled cycles then completion
    do_reset();
    step("idle", idle, O_DEF);
    for (int i = 0; i < 3; i++) step("dwait", dw, O_DW);
    step("dhit", dok, O_DEF);
    step("after", idle, O_DEF);
    chk("stall3", stall_cnt, 32'd3);
    step("dwen_wait", mk(1,0,0,1,0,0,0,0,0,0), O_DW);
    step("halt_over_wait", mk(1,0,1,0,0,1,0,0,0,0), O_HLT);

    // Halt is sticky and ignores later events
    step("halted", idle, O_OFF);
    step("halted_rdr", mk(1,0,0,0,1,0,0,0,0,0), O_OFF);
    step("halted_lu", mk(0,0,1,0,0,1,1,8,8,8), O_OFF);
    step("halted_end", idle, O_OFF);

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    step("post_rst", idle, O_DEF);
    step("rdr", mk(0,0,0,0,1,0,0,0,0,0), O_RDR);
    for (int i = 0; i < 5; i++) step("wait5", dw, O_DW);
    @(posedge CLK);
    #1;
    chk("pre_rst_stall", stall_cnt, 32'd5);
    chk("pre_rst_flush", flush_cnt, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    apply(idle);
    #1;
    chk("rst_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge CLK);
    nRST = 1'b1;
    m_halted = 1'b0; m_stall = '0; m_flush = '0;
    sbq.delete();
    step("rst_idle", idle, O_DEF);
    step("rst_lu", mk(1,0,0,0,0,0,1,8,8,0), O_LU);
    step("rst_end", idle, O_DEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
